// File: rtl/ctrl_pkg.sv
// Shared control types for the I2S receive path: bus standard, sizes, control word
// and the framer state encoding.
package ctrl_pkg;

  localparam int unsigned FLEN16 = 16;
  localparam int unsigned FLEN32 = 32;
  localparam int unsigned LENW   = 6;

  typedef enum logic [1:0] {I2S = 2'd0, MSB = 2'd1, LSB = 2'd2} standard_t;
  typedef enum logic [1:0] {WSZ16 = 2'd0, WSZ24 = 2'd1, WSZ32 = 2'd2} word_size_t;
  typedef enum logic {FSZ16 = 1'b0, FSZ32 = 1'b1} frame_size_t;

  typedef struct packed {
    standard_t   standard;
    word_size_t  word_size;
    frame_size_t frame_size;
    logic        stereo;
    logic        mute;
    logic        stop;
  } OP_t;

  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, RUN = 2'd2} rxf_state_t;

  function automatic logic [LENW-1:0] frame_len(input frame_size_t f);
    return (f == FSZ32) ? LENW'(FLEN32) : LENW'(FLEN16);
  endfunction

  // Word length clipped to the frame length.
  function automatic logic [LENW-1:0] word_len(input word_size_t w, input frame_size_t f);
    logic [LENW-1:0] n;
    case (w)
      WSZ16:   n = LENW'(16);
      WSZ24:   n = LENW'(24);
      default: n = LENW'(32);
    endcase
    return (n > frame_len(f)) ? frame_len(f) : n;
  endfunction

endpackage

// File: rtl/ws_edge_det.sv
// WS history and edge detection; the I2S standard compares one cycle later to
// absorb its one-bit data delay.
module ws_edge_det
  import ctrl_pkg::*;
(
  input  logic      sclk,
  input  logic      rst_,
  input  logic      ws,
  input  standard_t standard,
  output logic      ws_edge_c,
  output logic      new_ch_c
);

  logic ws_q, ws_q2;

  always_ff @(posedge sclk or negedge rst_) begin
    if (!rst_) begin
      ws_q  <= 1'b0;
      ws_q2 <= 1'b0;
    end else begin
      ws_q  <= ws;
      ws_q2 <= ws_q;
    end
  end

  assign ws_edge_c = (standard == I2S) ? (ws_q != ws_q2) : (ws != ws_q);
  assign new_ch_c  = (standard == I2S) ? ws_q : ws;

endmodule

// File: rtl/i2s_rx_framer.sv
// I2S receive framer: tracks WS framing, deserializes the capture window of each
// channel slot and pushes the word, tagged left/right, into the receive buffer.
module i2s_rx_framer
  import ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 6
) (
  input  logic             sclk,
  input  logic             rst_,
  input  logic             ws,
  input  logic             sd,
  input  OP_t              OP,
  input  logic             fifo_full,
  output logic [WIDTH-1:0] dout,
  output logic             ch,
  output logic             wr_en,
  output logic             overrun,
  output logic             frame_err
);

  localparam logic [CNTW-1:0] ONE = CNTW'(1);

  rxf_state_t       state, state_nxt;
  logic [CNTW-1:0]  cnt, cnt_nxt, f_q, w_q, f_c, w_c, slot_c, first_c, last_c;
  standard_t        std_q, std_c;
  logic             stereo_q, mute_q, stereo_c, mute_c, ch_q;
  logic [WIDTH-2:0] sh;
  logic [WIDTH-1:0] word_c;
  logic             ws_edge_c, new_ch_c, live_c, start_c, err_c;
  logic             cur_ch_c, in_win_c, push_c;

  // Latched configuration applies in RUN; the sync cycle itself uses the live word.
  assign std_c    = (state == RUN) ? std_q    : OP.standard;
  assign f_c      = (state == RUN) ? f_q      : CNTW'(frame_len(OP.frame_size));
  assign w_c      = (state == RUN) ? w_q      : CNTW'(word_len(OP.word_size, OP.frame_size));
  assign stereo_c = (state == RUN) ? stereo_q : OP.stereo;
  assign mute_c   = (state == RUN) ? mute_q   : OP.mute;

  ws_edge_det u_ws_edge_det (
    .sclk      (sclk),
    .rst_      (rst_),
    .ws        (ws),
    .standard  (std_c),
    .ws_edge_c (ws_edge_c),
    .new_ch_c  (new_ch_c)
  );

  always_ff @(posedge sclk or negedge rst_) begin
    if (!rst_) state <= IDLE;
    else       state <= state_nxt;
  end

  // cnt holds the previous slot; slot_c is the slot being sampled this cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    slot_c    = '0;
    live_c    = 1'b0;
    start_c   = 1'b0;
    err_c     = 1'b0;
    case (state)
      IDLE: state_nxt = SYNC;
      SYNC: begin
        if (ws_edge_c && !new_ch_c) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          live_c    = 1'b1;
          start_c   = 1'b1;
        end
      end
      RUN: begin
        if (cnt == f_c - ONE) begin
          if (ws_edge_c) begin
            cnt_nxt = '0;
            live_c  = 1'b1;
          end else begin
            err_c     = 1'b1;
            state_nxt = SYNC;
          end
        end else if (ws_edge_c) begin
          err_c     = 1'b1;
          state_nxt = SYNC;
        end else begin
          cnt_nxt = cnt + ONE;
          slot_c  = cnt + ONE;
          live_c  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (OP.stop) state_nxt = IDLE;
  end

  assign cur_ch_c = (live_c && slot_c == '0) ? new_ch_c : ch_q;
  assign first_c  = (std_c == LSB) ? f_c - w_c : '0;
  assign last_c   = (std_c == LSB) ? f_c - ONE : w_c - ONE;
  assign in_win_c = live_c && (slot_c >= first_c) && (slot_c <= last_c);
  assign word_c   = (slot_c == first_c) ? WIDTH'(sd) : {sh, sd};
  assign push_c   = in_win_c && (slot_c == last_c) && (stereo_c || !cur_ch_c);

  always_ff @(posedge sclk or negedge rst_) begin
    if (!rst_) begin
      cnt       <= '0;
      f_q       <= '0;
      w_q       <= '0;
      std_q     <= I2S;
      stereo_q  <= 1'b0;
      mute_q    <= 1'b0;
      ch_q      <= 1'b0;
      sh        <= '0;
      dout      <= '0;
      ch        <= 1'b0;
      wr_en     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (start_c) begin
        f_q      <= f_c;
        w_q      <= w_c;
        std_q    <= OP.standard;
        stereo_q <= OP.stereo;
        mute_q   <= OP.mute;
      end
      if (live_c)   ch_q <= cur_ch_c;
      if (in_win_c) sh   <= word_c[WIDTH-2:0];
      wr_en     <= push_c && !fifo_full;
      overrun   <= push_c && fifo_full;
      frame_err <= err_c;
      if (push_c && !fifo_full) begin
        dout <= mute_c ? '0 : word_c;
        ch   <= cur_ch_c;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_framer.sv
// Self-checking bench: builds serial WS/SD streams frame by frame and predicts
// pushes, overruns and framing errors from the bus-level framing rules.
module tb_i2s_rx_framer;
  import ctrl_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int N    = 1024;
  localparam int TAIL = 8;

  logic             sclk = 1'b0;
  logic             rst_, ws, sd, fifo_full;
  OP_t              op;
  logic [WIDTH-1:0] dout;
  logic             ch, wr_en, overrun, frame_err;

  i2s_rx_framer #(.WIDTH(WIDTH), .CNTW(6)) dut (
    .sclk(sclk), .rst_(rst_), .ws(ws), .sd(sd), .OP(op), .fifo_full(fifo_full),
    .dout(dout), .ch(ch), .wr_en(wr_en), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 sclk = ~sclk;

  int checks = 0;
  int failures = 0;

  bit          ws_a[N], sd_a[N], full_a[N], stop_a[N], rst_a[N];
  bit          exp_wr[N], exp_ov[N], exp_fe[N], exp_ch[N];
  logic [31:0] exp_dout[N];
  int          pos;
  int          fr_t0[$];
  bit          fr_c[$];
  int          std_i, flen, wlen;
  bit          stereo, mute;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", tag, $time, got, exp);
    end
  endtask

  task automatic begin_scn(input int s, input int f, input word_size_t wsz,
                           input bit st, input bit mu);
    int wb;
    std_i  = s;
    flen   = f;
    wb     = (wsz == WSZ16) ? 16 : (wsz == WSZ24) ? 24 : 32;
    wlen   = (wb > f) ? f : wb;
    stereo = st;
    mute   = mu;
    for (int i = 0; i < N; i++) begin
      ws_a[i] = 1'b1; sd_a[i] = 1'($urandom); full_a[i] = 1'b0;
      stop_a[i] = 1'b0; rst_a[i] = 1'b1;
      exp_wr[i] = 1'b0; exp_ov[i] = 1'b0; exp_fe[i] = 1'b0; exp_ch[i] = 1'b0;
      exp_dout[i] = '0;
    end
    fr_t0.delete();
    fr_c.delete();
    pos = 4;
    op.standard   = standard_t'(2'(s));
    op.word_size  = wsz;
    op.frame_size = (f == 32) ? FSZ32 : FSZ16;
    op.stereo     = st;
    op.mute       = mu;
  endtask

  // One channel slot of flen bits; shift=1 puts the MSB one cycle early.
  task automatic add_frame(input bit c, input logic [31:0] word, input int shift,
                           input bit full, input bit rec, input bit ones);
    int first;
    first = (std_i == 2) ? flen - wlen : 0;
    for (int s = 0; s < flen; s++) begin
      ws_a[pos+s]   = c;
      full_a[pos+s] = full;
      if (ones) sd_a[pos+s] = 1'b1;
    end
    if (std_i == 0) ws_a[pos-1] = c;
    for (int k = 0; k < wlen; k++) sd_a[pos+first+k-shift] = word[wlen-1-k];
    if (rec) begin
      fr_t0.push_back(pos);
      fr_c.push_back(c);
    end
    pos += flen;
  endtask

  // Left slot whose WS flips to right at slot 'at' (MSB/LSB standards).
  task automatic add_early(input int at);
    for (int s = 0; s < flen; s++) ws_a[pos+s] = (s >= at);
    exp_fe[pos+at+1] = 1'b1;
    pos += flen;
  endtask

  task automatic add_stop(input int at, input int len);
    for (int j = 0; j < len; j++) stop_a[pos+at+j] = 1'b1;
  endtask

  task automatic add_rst(input int at, input int len);
    for (int j = 0; j < len; j++) rst_a[pos+at+j] = 1'b0;
  endtask

  task automatic run_scn();
    int first, last, t0, idx;
    logic [31:0] wv;
    first = (std_i == 2) ? flen - wlen : 0;
    last  = (std_i == 2) ? flen - 1 : wlen - 1;
    foreach (fr_t0[n]) begin
      t0 = fr_t0[n];
      wv = '0;
      for (int k = 0; k < wlen; k++) wv = {wv[30:0], sd_a[t0+first+k]};
      if (stereo || !fr_c[n]) begin
        idx = t0 + last + 1;
        if (full_a[t0+last]) exp_ov[idx] = 1'b1;
        else begin
          exp_wr[idx]   = 1'b1;
          exp_dout[idx] = mute ? 32'h0 : wv;
          exp_ch[idx]   = fr_c[n];
        end
      end
    end
    for (int i = pos; i < pos + TAIL; i++) ws_a[i] = ws_a[pos-1];
    exp_fe[pos+1] = 1'b1;
    for (int i = 0; i < pos + TAIL; i++) begin
      @(negedge sclk);
      check("wr_en", 32'(wr_en), 32'(exp_wr[i]));
      check("overrun", 32'(overrun), 32'(exp_ov[i]));
      check("frame_err", 32'(frame_err), 32'(exp_fe[i]));
      if (exp_wr[i]) begin
        check("dout", dout, exp_dout[i]);
        check("ch", 32'(ch), 32'(exp_ch[i]));
      end
      ws = ws_a[i]; sd = sd_a[i]; fifo_full = full_a[i];
      op.stop = stop_a[i]; rst_ = rst_a[i];
      if (!rst_a[i]) begin
        #1;
        check("rst_dout", dout, 32'h0);
        check("rst_flags", 32'({wr_en, overrun, frame_err, ch}), 32'h0);
      end
    end
  endtask

  initial begin
    rst_ = 1'b0; ws = 1'b0; sd = 1'b0; fifo_full = 1'b0;
    op = '{standard: MSB, word_size: WSZ32, frame_size: FSZ32,
           stereo: 1'b1, mute: 1'b0, stop: 1'b0};
    repeat (3) @(negedge sclk);
    check("reset_dout", dout, 32'h0);
    check("reset_ch", 32'(ch), 32'h0);
    check("reset_wr_en", 32'(wr_en), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    rst_ = 1'b1;

    // MSB stereo, full-width words
    begin_scn(1, 32, WSZ32, 1'b1, 1'b0);
    add_frame(1'b0, 32'hA5A51234, 0, 1'b0, 1'b1, 1'b0);
    add_frame(1'b1, 32'hDEADBEEF, 0, 1'b0, 1'b1, 1'b0);
    run_scn();

    // I2S with correct one-bit delay, then with the MSB on the WS edge
    begin_scn(0, 16, WSZ16, 1'b1, 1'b0);
    add_frame(1'b0, 32'h8001, 0, 1'b0, 1'b1, 1'b0);
    add_frame(1'b1, $urandom, 0, 1'b0, 1'b1, 1'b0);
    add_frame(1'b0, 32'h8001, 1, 1'b0, 1'b1, 1'b0);
    add_frame(1'b1, $urandom, 0, 1'b0, 1'b1, 1'b0);
    run_scn();

    // LSB-justified 24-bit word in a 32-slot frame, leading slots all ones
    begin_scn(2, 32, WSZ24, 1'b1, 1'b0);
    add_frame(1'b0, 32'hC0FFEE, 0, 1'b0, 1'b1, 1'b1);
    add_frame(1'b1, $urandom, 0, 1'b0, 1'b1, 1'b0);
    run_scn();

    // Mono with a full buffer on the second left word
    begin_scn(1, 32, WSZ16, 1'b0, 1'b0);
    add_frame(1'b0, $urandom, 0, 1'b0, 1'b1, 1'b0);
    add_frame(1'b1, $urandom, 0, 1'b0, 1'b1, 1'b0);
    add_frame(1'b0, $urandom, 0, 1'b1, 1'b1, 1'b0);
    add_frame(1'b1, $urandom, 0, 1'b0, 1'b1, 1'b0);
    add_frame(1'b0, $urandom, 0, 1'b0, 1'b1, 1'b0);
    add_frame(1'b1, $urandom, 0, 1'b0, 1'b1, 1'b0);
    run_scn();

    // Early WS edge at slot 20, then resync
    begin_scn(1, 32, WSZ32, 1'b1, 1'b0);
    add_frame(1'b0, $urandom, 0, 1'b0, 1'b1, 1'b0);
    add_frame(1'b1, $urandom, 0, 1'b0, 1'b1, 1'b0);
    add_early(20);
    add_frame(1'b0, $urandom, 0, 1'b0, 1'b1, 1'b0);
    add_frame(1'b1, $urandom, 0, 1'b0, 1'b1, 1'b0);
    run_scn();

    // Stop mid-frame; the following right slot precedes resync and is dropped
    begin_scn(1, 32, WSZ32, 1'b1, 1'b0);
    add_frame(1'b0, $urandom, 0, 1'b0, 1'b1, 1'b0);
    add_frame(1'b1, $urandom, 0, 1'b0, 1'b1, 1'b0);
    add_stop(10, 3);
    add_frame(1'b0, $urandom, 0, 1'b0, 1'b0, 1'b0);
    add_frame(1'b1, $urandom, 0, 1'b0, 1'b0, 1'b0);
    add_frame(1'b0, $urandom, 0, 1'b0, 1'b1, 1'b0);
    add_frame(1'b1, $urandom, 0, 1'b0, 1'b1, 1'b0);
    run_scn();

    // Asynchronous reset mid-frame
    begin_scn(1, 32, WSZ32, 1'b1, 1'b0);
    add_frame(1'b0, $urandom, 0, 1'b0, 1'b1, 1'b0);
    add_frame(1'b1, $urandom, 0, 1'b0, 1'b1, 1'b0);
    add_rst(12, 2);
    add_frame(1'b0, $urandom, 0, 1'b0, 1'b0, 1'b0);
    add_frame(1'b1, $urandom, 0, 1'b0, 1'b0, 1'b0);
    add_frame(1'b0, $urandom, 0, 1'b0, 1'b1, 1'b0);
    add_frame(1'b1, $urandom, 0, 1'b0, 1'b1, 1'b0);
    run_scn();

    // Randomized configurations and traffic
    repeat (10) begin
      int nfr;
      begin_scn(int'($urandom_range(0, 2)), ($urandom_range(0, 1) == 1) ? 32 : 16,
                word_size_t'(2'($urandom_range(0, 2))),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      nfr = int'($urandom_range(4, 6));
      for (int n = 0; n < nfr; n++)
        add_frame(1'(n % 2), $urandom, 0, ($urandom_range(0, 3) == 0), 1'b1, 1'b0);
      run_scn();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
